instr_fetch: RTL and testbench

Instruction fetch unit for the MCU51 core, sitting directly downstream of the byte-wide program ROM. It drives the ROM's address and active-low chip select, collects the opcode and up to two operand bytes per instruction, and presents a complete instruction with its length and address to the decoder over a valid/ready handshake. It also accepts a jump redirect that reloads the program counter.

---
 rtl/instr_fetch.sv | 118 +++++++++++
 tb/tb_instr_fetch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// MCU51 instruction fetch: walks the byte-wide program ROM and
// assembles opcode plus operands for the decoder.
module instr_fetch #(
  parameter int ADDRWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 rom_cs,
  output logic [ADDRWIDTH-1:0] rom_addr,
  input  logic [7:0]           rom_data,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [7:0]           opcode,
  output logic [7:0]           operand1,
  output logic [7:0]           operand2,
  output logic [1:0]           instr_len,
  output logic [ADDRWIDTH-1:0] instr_pc,
  input  logic                 jump,
  input  logic [ADDRWIDTH-1:0] jump_addr
);

  typedef enum logic [2:0] {
    IDLE,
    F_OP,
    F_B1,
    F_B2,
    HOLD
  } state_t;

  state_t               state;
  state_t               nxt;
  logic [ADDRWIDTH-1:0] pc;
  logic [1:0]           dec_len;
  logic                 redirect;

  function automatic logic [1:0] len_of(input logic [7:0] op);
    logic [1:0] l;
    l = 2'd1;
    unique case (1'b1)
      (op == 8'h02) || (op == 8'h12) ||
      (op == 8'h75) || (op == 8'h90):
        l = 2'd3;
      (op[7:3] == 5'b01111) ||
      (op == 8'h24) || (op == 8'h60) ||
      (op == 8'h70) || (op == 8'h74) ||
      (op == 8'h80) || (op == 8'hE5) ||
      (op == 8'hF5):
        l = 2'd2;
      default:
        l = 2'd1;
    endcase
    return l;
  endfunction

  assign dec_len  = len_of(rom_data);
  assign redirect = jump && (state != IDLE);

  assign rom_addr    = pc;
  assign rom_cs      = !((state == F_OP) ||
                         (state == F_B1) ||
                         (state == F_B2));
  assign instr_valid = (state == HOLD);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state: fetch sequence sized by decoded length, jump overrides
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: nxt = F_OP;
      F_OP: nxt = (dec_len == 2'd1) ? HOLD : F_B1;
      F_B1: nxt = (instr_len == 2'd2) ? HOLD : F_B2;
      F_B2: nxt = HOLD;
      HOLD: if (instr_ready) nxt = F_OP;
      default: nxt = IDLE;
    endcase
    if (redirect) nxt = F_OP;
  end

  // PC and instruction fields: capture one ROM byte per fetch cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= '0;
      opcode    <= 8'h00;
      operand1  <= 8'h00;
      operand2  <= 8'h00;
      instr_len <= 2'd0;
      instr_pc  <= '0;
    end else if (redirect) begin
      pc <= jump_addr;
    end else begin
      unique case (state)
        F_OP: begin
          opcode    <= rom_data;
          operand1  <= 8'h00;
          operand2  <= 8'h00;
          instr_len <= dec_len;
          instr_pc  <= pc;
          pc        <= pc + ADDRWIDTH'(1);
        end
        F_B1: begin
          operand1 <= rom_data;
          pc       <= pc + ADDRWIDTH'(1);
        end
        F_B2: begin
          operand2 <= rom_data;
          pc       <= pc + ADDRWIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a falling-edge ROM model.
// Outputs are sampled 1ns after each rising edge.
module tb_instr_fetch;

  logic       clk;
  logic       rst_n;
  logic       rom_cs;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] opcode;
  logic [7:0] operand1;
  logic [7:0] operand2;
  logic [1:0] instr_len;
  logic [7:0] instr_pc;
  logic       jump;
  logic [7:0] jump_addr;

  logic [7:0] rom [256];
  int total;
  int bad;

  instr_fetch #(.ADDRWIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rom_cs(rom_cs),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .opcode(opcode),
    .operand1(operand1),
    .operand2(operand2),
    .instr_len(instr_len),
    .instr_pc(instr_pc),
    .jump(jump),
    .jump_addr(jump_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_instr(input string tag,
                           input logic [7:0] op,
                           input logic [7:0] b1,
                           input logic [7:0] b2,
                           input logic [1:0] len,
                           input logic [7:0] ipc);
    chk({tag, ".valid"}, instr_valid, 1);
    chk({tag, ".cs"}, rom_cs, 1);
    chk({tag, ".op"}, opcode, op);
    chk({tag, ".b1"}, operand1, b1);
    chk({tag, ".b2"}, operand2, b2);
    chk({tag, ".len"}, instr_len, len);
    chk({tag, ".pc"}, instr_pc, ipc);
  endtask

  initial begin
    total = 0;
    bad = 0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0] = 8'h74; rom[1] = 8'h55;
    rom[2] = 8'hF8; rom[3] = 8'hFF;
    rom[8'h10] = 8'h02; rom[8'h11] = 8'h12;
    rom[8'h12] = 8'h34;
    rom[8'hFE] = 8'h90; rom[8'hFF] = 8'hAB;
    rst_n = 1'b0;
    instr_ready = 1'b1;
    jump = 1'b0;
    jump_addr = 8'h00;
    #12;
    chk("rst.cs", rom_cs, 1);
    chk("rst.valid", instr_valid, 0);
    chk("rst.addr", rom_addr, 0);
    chk("rst.op", opcode, 0);
    chk("rst.len", instr_len, 0);
    chk("rst.ipc", instr_pc, 0);

    // Back-to-back stream with ready tied high
    do_reset();
    tick();
    chk("s1.fop.cs", rom_cs, 0);
    chk("s1.fop.addr", rom_addr, 8'h00);
    tick();
    chk("s1.fb1.valid", instr_valid, 0);
    chk("s1.fb1.addr", rom_addr, 8'h01);
    tick();
    chk_instr("s1.i0", 8'h74, 8'h55, 8'h00, 2, 8'h00);
    tick();
    chk("s1.fop2.addr", rom_addr, 8'h02);
    chk("s1.fop2.valid", instr_valid, 0);
    tick();
    chk_instr("s1.i1", 8'hF8, 8'h00, 8'h00, 1, 8'h02);
    tick();
    tick();
    chk_instr("s1.i2", 8'hFF, 8'h00, 8'h00, 1, 8'h03);
    tick();
    tick();
    chk_instr("s1.i3", 8'h00, 8'h00, 8'h00, 1, 8'h04);

    // Decoder stall in HOLD
    instr_ready = 1'b0;
    do_reset();
    tick();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk_instr("s2.hold", 8'h74, 8'h55, 8'h00, 2, 8'h00);
      chk("s2.addr", rom_addr, 8'h02);
      tick();
    end
    chk("s2.still", instr_valid, 1);
    instr_ready = 1'b1;
    tick();
    chk("s2.go.cs", rom_cs, 0);
    chk("s2.go.addr", rom_addr, 8'h02);
    chk("s2.go.valid", instr_valid, 0);

    // Jump during F_B1 discards the partial instruction
    do_reset();
    tick();
    tick();
    jump = 1'b1;
    jump_addr = 8'h10;
    tick();
    jump = 1'b0;
    chk("s3.j.addr", rom_addr, 8'h10);
    chk("s3.j.valid", instr_valid, 0);
    tick();
    chk("s3.b1.valid", instr_valid, 0);
    tick();
    chk("s3.b2.valid", instr_valid, 0);
    tick();
    chk_instr("s3.i", 8'h02, 8'h12, 8'h34, 3, 8'h10);

    // Instruction straddling the top of the address space
    rom[0] = 8'hCD;
    jump = 1'b1;
    jump_addr = 8'hFE;
    tick();
    jump = 1'b0;
    chk("s4.fop.addr", rom_addr, 8'hFE);
    tick();
    chk("s4.fb1.addr", rom_addr, 8'hFF);
    tick();
    chk("s4.fb2.addr", rom_addr, 8'h00);
    tick();
    chk_instr("s4.i", 8'h90, 8'hAB, 8'hCD, 3, 8'hFE);
    tick();
    chk("s4.next.addr", rom_addr, 8'h01);
    chk("s4.next.cs", rom_cs, 0);

    // Asynchronous reset in the middle of F_B2
    jump = 1'b1;
    jump_addr = 8'h10;
    tick();
    jump = 1'b0;
    tick();
    tick();
    chk("s5.fb2.cs", rom_cs, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5.rst.valid", instr_valid, 0);
    chk("s5.rst.cs", rom_cs, 1);
    chk("s5.rst.addr", rom_addr, 8'h00);
    chk("s5.rst.op", opcode, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("s5.re.addr", rom_addr, 8'h00);
    chk("s5.re.cs", rom_cs, 0);

    // Jump wins over a simultaneous handshake
    tick();
    chk_instr("s6.held", 8'hCD, 8'h00, 8'h00, 1, 8'h00);
    jump = 1'b1;
    jump_addr = 8'h03;
    tick();
    jump = 1'b0;
    chk("s6.j.valid", instr_valid, 0);
    chk("s6.j.addr", rom_addr, 8'h03);
    chk("s6.j.cs", rom_cs, 0);
    tick();
    chk_instr("s6.i", 8'hFF, 8'h00, 8'h00, 1, 8'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
